// File: rtl/note_sequencer_arb.sv
// rtl/note_sequencer_arb.sv - osc0 step sequencer merged with the SPI command stream (optional SEQ_LOOP_EN)
module note_sequencer_arb #(
   parameter int         TUNE_W   = 16,
   parameter int         DEPTH    = 16,
   parameter int         ADDR_W   = 4,
   parameter int         TIMER_W  = 24,
   parameter logic [7:0] CMD_TUNE = 8'h01,
   parameter logic [7:0] CMD_EN   = 8'h02
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [7:0]         ext_cmd_word,
   input  logic [TUNE_W-1:0]  ext_data_word,
   input  logic               ext_cmd_valid,
   input  logic               pat_wr_en,
   input  logic [ADDR_W-1:0]  pat_wr_addr,
   input  logic [TUNE_W-1:0]  pat_wr_data,
   input  logic               seq_run,
   input  logic [ADDR_W-1:0]  seq_last,
   input  logic [TIMER_W-1:0] step_period,
   input  logic [TIMER_W-1:0] gate_len,
   output logic [7:0]         cmd_word,
   output logic [TUNE_W-1:0]  data_word,
   output logic               cmd_valid,
   output logic               seq_busy,
   output logic [ADDR_W-1:0]  seq_step,
   output logic               seq_done
);

   typedef enum logic [2:0] {
      S_IDLE, S_FETCH, S_ISSUE_TUNE, S_ISSUE_ON, S_HOLD, S_ISSUE_OFF, S_WAIT_END, S_STOP_OFF
   } state_t;

   logic [TUNE_W-1:0]  pat_q [DEPTH];
   state_t             state_q;
   logic [TIMER_W-1:0] timer_q, period_q, gate_q;
   logic [ADDR_W-1:0]  step_q, last_q;
   logic [TUNE_W-1:0]  entry_q;
   logic               note_on_q, held_q, busy_q, done_q;
   logic [7:0]         cmd_q;
   logic [TUNE_W-1:0]  data_q;
   logic               valid_q;

   logic               seq_req, seq_fire, abort, step_end, end_hit, timer_run;
   logic [7:0]         seq_cmd;
   logic [TUNE_W-1:0]  seq_data;
   logic [TIMER_W-1:0] period_in;
   logic [ADDR_W-1:0]  last_in;

   assign period_in = (step_period == '0) ? TIMER_W'(1) : step_period;
   assign last_in   = ({1'b0, seq_last} >= (ADDR_W+1)'(DEPTH)) ? ADDR_W'(DEPTH-1) : seq_last;
   assign step_end  = (timer_q >= period_q - TIMER_W'(1));

   // Sequencer command request, grant (external stream wins) and step-end detection
   always_comb begin
      seq_req  = 1'b0;
      seq_cmd  = CMD_EN;
      seq_data = '0;
      case (state_q)
         S_ISSUE_TUNE: begin
            seq_req  = 1'b1;
            seq_cmd  = CMD_TUNE;
            seq_data = entry_q;
         end
         S_ISSUE_ON: begin
            seq_req  = 1'b1;
            seq_data = TUNE_W'(1);
         end
         S_ISSUE_OFF, S_STOP_OFF: seq_req = 1'b1;
         default: ;
      endcase
      // STOP_OFF is itself the abort path, so it must still complete with seq_run low
      abort     = !seq_run && (state_q != S_IDLE) && (state_q != S_STOP_OFF);
      seq_fire  = seq_req && !ext_cmd_valid && !abort;
      // the step clock freezes while a command waits for the decoder input
      timer_run = (state_q != S_IDLE) && !(seq_req && !seq_fire);
      end_hit   = ((state_q == S_HOLD) && !((gate_q < period_q) && (timer_q >= gate_q)) && step_end) ||
                  ((state_q == S_WAIT_END) && step_end);
   end

   // Pattern memory: writes land next cycle, cleared on reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) pat_q[i] <= '0;
      end else if (pat_wr_en) begin
         pat_q[pat_wr_addr] <= pat_wr_data;
      end
   end

   // Registered decoder-side command port
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cmd_q   <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
      end else if (ext_cmd_valid) begin
         cmd_q   <= ext_cmd_word;
         data_q  <= ext_data_word;
         valid_q <= 1'b1;
      end else if (seq_fire) begin
         cmd_q   <= seq_cmd;
         data_q  <= seq_data;
         valid_q <= 1'b1;
      end else begin
         valid_q <= 1'b0;
      end
   end

   // Sequencer FSM with step timer, note state and status outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         timer_q   <= '0;
         period_q  <= '0;
         gate_q    <= '0;
         step_q    <= '0;
         last_q    <= '0;
         entry_q   <= '0;
         note_on_q <= 1'b0;
         held_q    <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         done_q <= 1'b0;
         // a finished one-shot pass stays parked until seq_run is released
         if (!seq_run) held_q <= 1'b0;
         if (timer_run) timer_q <= timer_q + TIMER_W'(1);
         if (abort) begin
            state_q <= note_on_q ? S_STOP_OFF : S_IDLE;
            busy_q  <= note_on_q;
         end else if (end_hit) begin
            timer_q <= '0;
            if (step_q == last_q) begin
               done_q <= 1'b1;
`ifdef SEQ_LOOP_EN
               step_q  <= '0;
               state_q <= S_FETCH;
`else
               held_q <= 1'b1;
               if (note_on_q) begin
                  state_q <= S_STOP_OFF;
               end else begin
                  state_q <= S_IDLE;
                  busy_q  <= 1'b0;
               end
`endif
            end else begin
               step_q  <= step_q + ADDR_W'(1);
               state_q <= S_FETCH;
            end
         end else begin
            case (state_q)
               S_IDLE: if (seq_run && !held_q) begin
                  state_q <= S_FETCH;
                  step_q  <= '0;
                  timer_q <= '0;
                  busy_q  <= 1'b1;
               end
               S_FETCH: begin
                  entry_q  <= pat_q[step_q];
                  period_q <= period_in;
                  gate_q   <= gate_len;
                  last_q   <= last_in;
                  if ((pat_q[step_q] != '0) && (gate_len != '0)) state_q <= S_ISSUE_TUNE;
                  else if (note_on_q)                              state_q <= S_ISSUE_OFF;
                  else                                             state_q <= S_WAIT_END;
               end
               S_ISSUE_TUNE: if (seq_fire) state_q <= note_on_q ? S_HOLD : S_ISSUE_ON;
               S_ISSUE_ON: if (seq_fire) begin
                  note_on_q <= 1'b1;
                  state_q   <= S_HOLD;
               end
               S_HOLD: if ((gate_q < period_q) && (timer_q >= gate_q)) state_q <= S_ISSUE_OFF;
               S_ISSUE_OFF: if (seq_fire) begin
                  note_on_q <= 1'b0;
                  state_q   <= S_WAIT_END;
               end
               S_STOP_OFF: if (seq_fire) begin
                  note_on_q <= 1'b0;
                  state_q   <= S_IDLE;
                  busy_q    <= 1'b0;
               end
               default: ;
            endcase
         end
      end
   end

   assign cmd_word  = cmd_q;
   assign data_word = data_q;
   assign cmd_valid = valid_q;
   assign seq_busy  = busy_q;
   assign seq_step  = step_q;
   assign seq_done  = done_q;

endmodule

// File: tb/tb_note_sequencer_arb.sv
// tb/tb_note_sequencer_arb.sv - randomized self-checking bench for note_sequencer_arb
module tb_note_sequencer_arb;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [7:0]  ext_cmd_word;
   logic [15:0] ext_data_word;
   logic        ext_cmd_valid;
   logic        pat_wr_en;
   logic [3:0]  pat_wr_addr;
   logic [15:0] pat_wr_data;
   logic        seq_run;
   logic [3:0]  seq_last;
   logic [23:0] step_period;
   logic [23:0] gate_len;
   logic [7:0]  cmd_word;
   logic [15:0] data_word;
   logic        cmd_valid;
   logic        seq_busy;
   logic [3:0]  seq_step;
   logic        seq_done;

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [23:0] exp_q[$];
   logic [15:0] pat_m [16];
   logic        mon_en = 1'b0;
   logic        ext_v_q = 1'b0;
   logic [7:0]  ext_w_q = '0;
   logic [15:0] ext_d_q = '0;
   logic [23:0] mon_e;
   int          cyc = 0;
   int          t_tune = 0;
   int          t_off = 0;

   note_sequencer_arb dut (
      .clk(clk), .rst_n(rst_n),
      .ext_cmd_word(ext_cmd_word), .ext_data_word(ext_data_word), .ext_cmd_valid(ext_cmd_valid),
      .pat_wr_en(pat_wr_en), .pat_wr_addr(pat_wr_addr), .pat_wr_data(pat_wr_data),
      .seq_run(seq_run), .seq_last(seq_last), .step_period(step_period), .gate_len(gate_len),
      .cmd_word(cmd_word), .data_word(data_word), .cmd_valid(cmd_valid),
      .seq_busy(seq_busy), .seq_step(seq_step), .seq_done(seq_done)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // capture what the DUT saw on the external port at each edge
   initial forever begin
      @(posedge clk);
      ext_v_q = ext_cmd_valid;
      ext_w_q = ext_cmd_word;
      ext_d_q = ext_data_word;
   end

   // output monitor: ext commands must appear one cycle later, everything else follows the model queue
   initial forever begin
      @(negedge clk);
      cyc++;
      if (mon_en && rst_n) begin
         if (ext_v_q) begin
            check_eq("pass_valid", 32'(cmd_valid), 32'd1);
            check_eq("pass_word", 32'(cmd_word), 32'(ext_w_q));
            check_eq("pass_data", 32'(data_word), 32'(ext_d_q));
         end else if (cmd_valid) begin
            if (exp_q.size() == 0) begin
               check_eq("seq_unexpected", 32'({cmd_word, data_word}), 32'd0);
            end else begin
               mon_e = exp_q.pop_front();
               check_eq("seq_cmd", 32'({cmd_word, data_word}), 32'(mon_e));
            end
            if (cmd_word == 8'h01) t_tune = cyc;
            if ({cmd_word, data_word} == 24'h020000) t_off = cyc;
         end
      end
   end

   task automatic wr_pat(input int addr, input logic [15:0] d);
      @(negedge clk);
      pat_wr_en   = 1'b1;
      pat_wr_addr = 4'(addr);
      pat_wr_data = d;
      pat_m[addr] = d;
      @(negedge clk);
      pat_wr_en = 1'b0;
   endtask

   task automatic cfg(input int last, input int per, input int gate);
      seq_last    = 4'(last);
      step_period = 24'(per);
      gate_len    = 24'(gate);
   endtask

   // one pass computed from the note/rest/gate rules, independent of cycle timing
   task automatic model_pass(input int last, input int per, input int gate);
      bit on;
      int p;
      on = 0;
      p  = (per == 0) ? 1 : per;
      for (int k = 0; k <= last; k++) begin
         if (pat_m[k] != 0 && gate != 0) begin
            exp_q.push_back({8'h01, pat_m[k]});
            if (!on) begin
               exp_q.push_back(24'h020001);
               on = 1;
            end
            if (gate < p) begin
               exp_q.push_back(24'h020000);
               on = 0;
            end
         end else if (on) begin
            exp_q.push_back(24'h020000);
            on = 0;
         end
      end
      if (on) exp_q.push_back(24'h020000);
   endtask

   task automatic play(input int ext_rate, input int coll, input int abort_at,
                       input int exp_done, input int exp_dur);
      int t_b, t_d, dn;
      bit fin;
      t_b = -1; t_d = -1; dn = 0; fin = 0;
      @(negedge clk);
      seq_run = 1'b1;
      for (int i = 0; i < 5000 && !fin; i++) begin
         @(negedge clk);
         if (seq_busy && t_b < 0) t_b = i;
         if (seq_done) begin
            t_d = i;
            dn++;
         end
         if (coll != 0 && t_b >= 0 && i == t_b + 2) check_eq("coll_ext_first", 32'({cmd_valid, cmd_word}), 32'h15A);
         if (coll != 0 && t_b >= 0 && i == t_b + 3) check_eq("coll_tune_next", 32'({cmd_valid, cmd_word}), 32'h101);
         if (t_b >= 0 && !seq_busy) begin
            fin = 1;
         end else begin
            ext_cmd_valid = 1'b0;
            if (coll != 0 && t_b >= 0 && i == t_b + 1) begin
               ext_cmd_valid = 1'b1;
               ext_cmd_word  = 8'h5A;
               ext_data_word = 16'hBEEF;
            end else if (ext_rate > 0 && $urandom_range(99) < ext_rate) begin
               ext_cmd_valid = 1'b1;
               ext_cmd_word  = 8'($urandom);
               ext_data_word = 16'($urandom);
            end
            if (abort_at > 0 && t_b >= 0 && i == t_b + abort_at) seq_run = 1'b0;
         end
      end
      ext_cmd_valid = 1'b0;
      seq_run = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check_eq("play_finished", 32'(fin), 32'd1);
      check_eq("seq_left", 32'(exp_q.size()), 32'd0);
      check_eq("done_cnt", 32'(dn), 32'(exp_done));
      if (exp_dur >= 0) check_eq("pass_len", 32'(t_d - t_b), 32'(exp_dur));
      exp_q.delete();
   endtask

   initial begin
      rst_n = 1'b0;
      ext_cmd_word = '0; ext_data_word = '0; ext_cmd_valid = 1'b0;
      pat_wr_en = 1'b0; pat_wr_addr = '0; pat_wr_data = '0;
      seq_run = 1'b0;
      cfg(0, 0, 0);
      for (int i = 0; i < 16; i++) pat_m[i] = '0;
      repeat (3) @(negedge clk);
      check_eq("rst_valid", 32'(cmd_valid), 32'd0);
      check_eq("rst_word", 32'({cmd_word, data_word}), 32'd0);
      check_eq("rst_busy", 32'(seq_busy), 32'd0);
      check_eq("rst_step", 32'(seq_step), 32'd0);
      check_eq("rst_done", 32'(seq_done), 32'd0);
      rst_n = 1'b1;
      mon_en = 1'b1;
      repeat (2) @(negedge clk);

      // pass-through: valid in one cycle, visible the next cycle only
      ext_cmd_valid = 1'b1; ext_cmd_word = 8'h05; ext_data_word = 16'h1234;
      @(negedge clk);
      check_eq("pt_valid", 32'(cmd_valid), 32'd1);
      check_eq("pt_word", 32'(cmd_word), 32'h05);
      check_eq("pt_data", 32'(data_word), 32'h1234);
      ext_cmd_valid = 1'b0;
      @(negedge clk);
      check_eq("pt_single", 32'(cmd_valid), 32'd0);

      // basic play: note, rest, note
      wr_pat(0, 16'h0400); wr_pat(1, 16'h0000); wr_pat(2, 16'h0800);
      cfg(2, 100, 40);
      exp_q = '{24'h010400, 24'h020001, 24'h020000, 24'h010800, 24'h020001, 24'h020000};
      play(0, 0, 0, 1, 300);
      check_eq("gate_gap", 32'(t_off - t_tune), 32'd40);

      // collision with a pending TUNE stretches the step by one cycle
      cfg(0, 100, 40);
      exp_q = '{24'h010400, 24'h020001, 24'h020000};
      play(0, 1, 0, 1, 101);

      // legato: gate >= period keeps the note on across steps
      wr_pat(1, 16'h0500);
      cfg(1, 100, 100);
      exp_q = '{24'h010400, 24'h020001, 24'h010500, 24'h020000};
      play(0, 0, 0, 1, 200);

      // abort during HOLD with the note on
      cfg(0, 100, 100);
      exp_q = '{24'h010400, 24'h020001, 24'h020000};
      play(0, 0, 50, 0, -1);
      check_eq("abort_idle", 32'(seq_busy), 32'd0);

      // randomized patterns with random external traffic
      for (int it = 0; it < 8; it++) begin
         int last, per, gate;
         last = $urandom_range(4);
         per  = $urandom_range(12);
         gate = $urandom_range(14);
         for (int k = 0; k <= last; k++)
            wr_pat(k, ($urandom_range(1) == 0) ? 16'h0000 : 16'($urandom_range(16'hFFFF, 1)));
         cfg(last, per, gate);
         model_pass(last, per, gate);
         play(20, 0, 0, 1, -1);
      end

      // reset in the middle of a note
      wr_pat(0, 16'h0400); wr_pat(1, 16'h0000); wr_pat(2, 16'h0800);
      cfg(2, 20, 10);
      mon_en = 1'b0;
      @(negedge clk);
      seq_run = 1'b1;
      for (int i = 0; i < 10 && !seq_busy; i++) @(negedge clk);
      repeat (45) @(negedge clk);
      check_eq("pre_rst_step", 32'(seq_step), 32'd2);
      rst_n = 1'b0;
      #1;
      check_eq("mid_rst_valid", 32'(cmd_valid), 32'd0);
      check_eq("mid_rst_busy", 32'(seq_busy), 32'd0);
      check_eq("mid_rst_step", 32'(seq_step), 32'd0);
      seq_run = 1'b0;
      for (int i = 0; i < 16; i++) pat_m[i] = '0;
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check_eq("post_rst_quiet", 32'(cmd_valid), 32'd0);
      end
      mon_en = 1'b1;

      // pattern memory was cleared by reset: every step is a rest
      cfg(1, 5, 3);
      model_pass(1, 5, 3);
      play(0, 0, 0, 1, 10);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
